// File: rtl/seq_logical_left_shift_pkg.sv
// Shared ALU shifter package.
// Holds the datapath width, shift-amount width, the shifter FSM state encoding and the largest
// legal shift amount. MAX_SHAMT is also used by the right shifter for its range check.
package seq_logical_left_shift_pkg;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned SHAMT_W = 4;

  // Any shift amount above this value forces a zero result.
  localparam logic [WIDTH-1:0] MAX_SHAMT = WIDTH'(15);

  // Encoding 2'd3 is illegal and recovers to StIdle.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StFinish = 2'd2
  } shift_state_e;

endpackage

// File: rtl/seq_logical_left_shift_if.sv
// Start/busy/done handshake bundle for the sequential left shifter.
//   start    : request pulse, sampled when the shifter is not busy
//   a, b     : operand and unsigned shift amount, sampled on an accepted start
//   busy     : shift in progress
//   done     : one-cycle pulse when out/overflow become valid
//   out      : shifted result, held between operations
//   overflow : a 1 bit was shifted out past the MSB
// master drives the request side, slave is the shifter.
interface seq_logical_left_shift_if;
  import seq_logical_left_shift_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, out, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, out, overflow
  );

endinterface

// File: rtl/seq_logical_left_shift_lsl_step_1bit.sv
// One step of the sequential logical left shift (combinational).
//   sreg_i : current shift register        sreg_o : shift register moved left by one, LSB zero
//   acc_i  : current overflow accumulator  acc_o  : accumulator ORed with the bit leaving the MSB
module seq_logical_left_shift_lsl_step_1bit
  import seq_logical_left_shift_pkg::*;
(
  input  logic [WIDTH-1:0] sreg_i,
  input  logic             acc_i,
  output logic [WIDTH-1:0] sreg_o,
  output logic             acc_o
);

  always_comb begin
    sreg_o = {sreg_i[WIDTH-2:0], 1'b0};
    acc_o  = acc_i | sreg_i[WIDTH-1];
  end

endmodule

// File: rtl/seq_logical_left_shift.sv
// Multi-cycle logical left shifter: shifts a left by b, one bit per clock, zero-filling from the
// LSB. Shift amounts above MAX_SHAMT give a zero result with overflow = |a.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : start/a/b request in, busy/done/out/overflow out (all outputs registered)
module seq_logical_left_shift
  import seq_logical_left_shift_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  seq_logical_left_shift_if.slave bus
);

  shift_state_e       state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic               acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   step_sreg;
  logic               step_acc;
  logic               accept;
  logic               out_of_range;
  logic               zero_shamt;
  logic               last_step;

  seq_logical_left_shift_lsl_step_1bit u_step (
    .sreg_i (sreg_q),
    .acc_i  (acc_q),
    .sreg_o (step_sreg),
    .acc_o  (step_acc)
  );

  // FINISH accepts a new start just like IDLE, so results can stream back to back.
  assign accept       = bus.start && ((state_q == StIdle) || (state_q == StFinish));
  assign out_of_range = bus.b > MAX_SHAMT;
  assign zero_shamt   = (bus.b[SHAMT_W-1:0] == '0);
  assign last_step    = (cnt_q == SHAMT_W'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StIdle, StFinish: begin
        if (accept) begin
          state_d = (out_of_range || zero_shamt) ? StFinish : StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: state_d = last_step ? StFinish : StShift;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode straight from registered state, so no input reaches an output combinationally.
  always_comb begin
    bus.busy     = (state_q == StShift);
    bus.done     = (state_q == StFinish);
    bus.out      = out_q;
    bus.overflow = ovf_q;
  end

  // Datapath next-state
  always_comb begin
    sreg_d = sreg_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    ovf_d  = ovf_q;
    if (accept) begin
      sreg_d = bus.a;
      acc_d  = 1'b0;
      cnt_d  = '0;
      if (out_of_range) begin
        sreg_d = '0;
        acc_d  = |bus.a;
        out_d  = '0;
        ovf_d  = |bus.a;
      end else if (zero_shamt) begin
        out_d = bus.a;
        ovf_d = 1'b0;
      end else begin
        cnt_d = bus.b[SHAMT_W-1:0];
      end
    end else if (state_q == StShift) begin
      sreg_d = step_sreg;
      acc_d  = step_acc;
      cnt_d  = cnt_q - SHAMT_W'(1);
      // Publish the final step directly so out/overflow are valid the cycle done is high.
      if (last_step) begin
        out_d = step_sreg;
        ovf_d = step_acc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      acc_q  <= 1'b0;
      cnt_q  <= '0;
      out_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: doc/seq_logical_left_shift.md
Name: seq_logical_left_shift

Overview:
- Multi-cycle logical left shifter for the 16-bit ALU datapath; the opposite direction of the combinational logical right shifter.
- Shifts operand A left by B[3:0], one bit per clock, zero-filling from the LSB.
- Any B above 15 forces a zero result.
- Start/busy/done handshake; result and overflow are registered and held until the next accepted start.

Parameters:
- WIDTH, 16, operand/result width.
- SHAMT_W, 4, shift-amount width (log2 WIDTH).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled when not busy.
- A  input  16  operand to shift; sampled on accepted start.
- B  input  16  shift amount, unsigned; sampled on accepted start.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse when out/overflow become valid.
- out  output  16  shifted result, held between operations.
- overflow  output  1  high if any 1 bit was shifted out of bit 15.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, out=16'h0000, overflow=0, internal shift register and counter cleared. Holds while rst=1; an in-flight operation is abandoned with no done.
- States: IDLE, SHIFT, FINISH.
- IDLE, start=1 (accepted start):
  - Latch A into sreg, clear the overflow accumulator.
  - If B[15:4]!=0 (B>15): load result 0, accumulator = |A, go to FINISH.
  - Else if B[3:0]==0: go to FINISH with sreg=A.
  - Else load cnt=B[3:0], go to SHIFT.
- SHIFT, each cycle:
  - acc <= acc | sreg[15]
  - sreg <= {sreg[14:0],1'b0}
  - cnt <= cnt-1
  - When cnt==1 on this cycle, go to FINISH next.
- FINISH (exactly one cycle):
  - done=1.
  - out <= result; overflow <= accumulator, both registered on the edge entering FINISH so they are valid while done=1.
  - Next state IDLE.
  - start=1 during FINISH is accepted exactly as in IDLE (back-to-back operation, no bubble).
- busy=1 in SHIFT and in the cycle after acceptance; busy=0 in IDLE and FINISH.
- start while busy=1 is ignored; A/B changes during busy have no effect.
- Latency: done asserts shamt+1 cycles after the accepting edge, for shamt 0..15. Out-of-range B gives done after 1 cycle.
- Throughput: one result per shamt+1 cycles.
- out/overflow are not disturbed during a shift; they change only on the edge entering FINISH.
- overflow definition: OR of all bits shifted past bit 15, i.e. A[15:16-shamt]!=0. shamt=0 gives overflow=0; B>15 gives overflow=|A.
- Width rules: all arithmetic is unsigned. cnt is SHAMT_W bits and never wraps below 1 inside SHIFT.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared ALU package holds WIDTH=16, SHAMT_W=4, the state encoding (IDLE=2'd0, SHIFT=2'd1, FINISH=2'd2, 2'd3 illegal → IDLE), and the MAX_SHAMT=15 constant, which is shared with the right shifter's range check.
- One natural sub-module: lsl_step_1bit. It is combinational and takes sreg and acc, returning next sreg and next acc. It is instantiated once, with the FSM/counter in the top level.

Test Plan:
- Reset mid-shift: start A=16'h00FF B=8, assert rst after 3 cycles → out=0, overflow=0, busy=0, no done pulse. After release, IDLE accepts a new start.
- Basic shift: A=16'h00F0 B=4 → done 5 cycles after start, out=16'h0F00, overflow=0. busy high 4 cycles. Result holds until next start.
- Overflow: A=16'hC001 B=1 → out=16'h8002, overflow=1, done at cycle 2. A=16'h8000 B=15 → out=0, overflow=1, done at cycle 16.
- Zero and out-of-range: A=16'h1234 B=0 → out=16'h1234, overflow=0, done at cycle 1. A=16'h1234 B=16 → out=0, overflow=1, done at cycle 1. A=0 B=16'hFFFF → out=0, overflow=0.
- Handshake: start held high during busy, with A/B changed mid-op → first result unaffected (A=16'h0001 B=3 → 16'h0008). A second start held in the FINISH cycle with A=16'h0003 B=2 → accepted immediately, out=16'h000C three cycles later.
- Sweep: A=16'hA5A5, B=0..15 back-to-back → each out=(A<<B)&16'hFFFF, overflow=((A>>(16-B))!=0), and done spacing = B+1 cycles.
